simd_mem_req_arbiter: RTL and testbench
=======================================

# simd_mem_req_arbiter

Round-robin arbiter that shares the SIMD store-path 4 KB request splitter (`mem_request_splitter_simd`) among `NUM_REQ` requesters. It accepts one request at a time, pulses it into the splitter, and holds off the next grant until the splitter reports completion. It also tracks outstanding AXI write transactions and throttles grants against a credit limit. It sits between the SIMD store generators and the splitter/AXI write-address stage.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `ADDR_WIDTH`, 64: byte-address width.
- `REQ_SIZE_WIDTH`, 16: request size width, in bytes.
- `MAX_OUTSTANDING`, 8: AXI write transactions allowed in flight, ≥2.
- `clk`  in  1  block clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester request valid.
- `req_addr`  in  NUM_REQ×ADDR_WIDTH  per-requester start address.
- `req_size`  in  NUM_REQ×REQ_SIZE_WIDTH  per-requester size, in bytes.
- `req_ready`  out  NUM_REQ  one-hot acceptance strobe.
- `spl_addr`  out  ADDR_WIDTH  address to the splitter `addr_in`.
- `spl_addr_valid`  out  1  one-cycle pulse to the splitter `addr_in_valid`.
- `spl_size`  out  REQ_SIZE_WIDTH  size to the splitter `input_req_size_bytes`.
- `spl_issue`  in  1  splitter `addr_out_valid`; one AXI AW is issued per high cycle.
- `spl_complete`  in  1  splitter `split_sm_complete`.
- `wr_resp_valid`  in  1  AXI B-channel handshake; retires one transaction.
- `grant_id`  out  clog2(NUM_REQ)  owner of the current transaction.
- `busy`  out  1  high whenever the state is not IDLE.
- `credit_err`  out  1  sticky flag; set on a response received with zero outstanding.

## Operation
- States:
  - IDLE → ISSUE: on acceptance.
  - ISSUE → ARM: unconditional.
  - ARM → WAIT_DONE: unconditional.
  - WAIT_DONE → IDLE: when `spl_complete`=1.
- Acceptance happens in IDLE only, and only when some `req_valid` bit is set and `outstanding ≤ MAX_OUTSTANDING-2`. This leaves headroom for a split that produces 2 AW beats.
- Winner selection:
  - The winner is the first valid requester scanning from `last_grant+1` upward, wrapping at `NUM_REQ`.
  - `req_ready[winner]`=1 for that single cycle. `req_addr`/`req_size` of the winner are latched, and `grant_id` and `last_grant` are updated.
- ISSUE: `spl_addr_valid`=1 and `spl_addr`/`spl_size` are driven from the latched values.
- ARM: one dead cycle. It exists because the splitter's complete flag is still high from its idle state.
- WAIT_DONE: ignores `req_valid` until the splitter reports completion.
- Outstanding counter, width clog2(MAX_OUTSTANDING+1):
  - +1 per `spl_issue` cycle, −1 per `wr_resp_valid` cycle.
  - Both in the same cycle: the counter is unchanged.
  - `wr_resp_valid` with the counter at 0: the counter holds at 0 and `credit_err` is set.
  - Overflow is impossible given the acceptance rule.
- A requester must hold `req_valid`, `req_addr` and `req_size` stable until it sees `req_ready`. `req_valid` dropping before grant is legal; that requester simply loses its turn.

## Timing
- Reset values: `req_ready`=0, `spl_addr_valid`=0, `spl_addr`=0, `spl_size`=0, `grant_id`=0, `busy`=0, `credit_err`=0, outstanding=0, state=IDLE, `last_grant`=NUM_REQ-1 (requester 0 wins first).
- Latency: acceptance in cycle T, `spl_addr_valid` in T+1, earliest next acceptance in T+4, since WAIT_DONE returns to IDLE in T+3 if `spl_complete` is already high.
- `req_ready` is combinational from `req_valid` and state. All other outputs are registered.
- Reset asserted mid-transaction aborts everything: the next cycle is IDLE with all counters cleared. The splitter is reset by the same `reset`.

## Configuration
- `SIMD_ARB_PERF_CNT_EN` defined:
  - Adds a 32-bit per-requester grant counter, incremented on each acceptance and saturating at all-ones.
  - Adds a 32-bit stall counter, incremented in IDLE cycles where a request is pending but credit is blocked.
  - Exposed as `perf_grant_cnt` (NUM_REQ×32) and `perf_stall_cnt` (32); all reset to 0.
- Undefined: these ports and counters do not exist, and behaviour is otherwise identical.

## Structure
- Shared package `simd_arb_pkg`: state enum `simd_arb_state_e` {IDLE, ISSUE, ARM, WAIT_DONE} and the `SIMD_ARB_CNT_W`=32 constant.
- One sub-module, `rr_pick`: a combinational round-robin priority picker taking `valid` and `last_grant`, producing a one-hot `winner` and `any`. It is reusable by other SIMD arbiters.

## Test plan
- Single requester 0, addr 0x1000, size 256, splitter completes 4 cycles after the pulse → `req_ready[0]` at T, `spl_addr_valid` at T+1 with 0x1000/256, `busy` low after completion, outstanding = 1 after one `spl_issue`.
- All 4 requesters valid continuously → grant order 0,1,2,3,0; `grant_id` matches each `spl_addr_valid` pulse.
- MAX_OUTSTANDING=4, 3 issued with no responses → no grant while outstanding=3; one `wr_resp_valid` → grant in the following IDLE cycle.
- Split request addr 0x0FC0, size 128 producing 2 `spl_issue` pulses → outstanding +2; next requester waits until `spl_complete`.
- `spl_issue` and `wr_resp_valid` in the same cycle with outstanding=2 → stays 2. `wr_resp_valid` at outstanding=0 → `credit_err`=1 and stays set.
- Reset asserted during WAIT_DONE → next cycle state IDLE, outstanding 0, first grant after release goes to requester 0.

Source files
------------

// File: rtl/simd_mem_req_arbiter_pkg.sv
// simd_mem_req_arbiter shared package
// State encoding and counter width shared by the arbiter files
package simd_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        ARM       = 2'd2,
        WAIT_DONE = 2'd3
    } simd_arb_state_e;

    localparam int SIMD_ARB_CNT_W = 32;

endpackage

// File: rtl/simd_mem_req_arbiter_if.sv
// simd_mem_req_arbiter bus interface
// Requester, splitter and AXI-B signals; slave = arbiter side
interface simd_mem_req_arbiter_if #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_WIDTH     = 64,
    parameter int REQ_SIZE_WIDTH = 16
);
    localparam int GW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]                     req_valid;
    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]     req_addr;
    logic [NUM_REQ-1:0][REQ_SIZE_WIDTH-1:0] req_size;
    logic [NUM_REQ-1:0]                     req_ready;
    logic [ADDR_WIDTH-1:0]                  spl_addr;
    logic                                   spl_addr_valid;
    logic [REQ_SIZE_WIDTH-1:0]              spl_size;
    logic                                   spl_issue;
    logic                                   spl_complete;
    logic                                   wr_resp_valid;
    logic [GW-1:0]                          grant_id;
    logic                                   busy;
    logic                                   credit_err;

    modport slave (
        input  req_valid, req_addr, req_size,
        input  spl_issue, spl_complete, wr_resp_valid,
        output req_ready, spl_addr, spl_addr_valid, spl_size,
        output grant_id, busy, credit_err
    );

    modport master (
        output req_valid, req_addr, req_size,
        output spl_issue, spl_complete, wr_resp_valid,
        input  req_ready, spl_addr, spl_addr_valid, spl_size,
        input  grant_id, busy, credit_err
    );

endinterface

// File: rtl/simd_mem_req_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority picker
// Scans upward from last_grant+1, wrapping at N; one-hot result
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         i_valid,
    input  logic [$clog2(N)-1:0] i_last_grant,
    output logic [N-1:0]         o_winner,
    output logic                 o_any
);
    localparam int IW = $clog2(N);

    int          w_tmp;
    logic [IW-1:0] w_idx;

    // Walk offsets from farthest to nearest so the nearest valid wins
    always_comb begin
        o_winner = '0;
        w_tmp    = 0;
        w_idx    = '0;
        for (int off = N; off >= 1; off--) begin
            w_tmp = (int'(i_last_grant) + off) % N;
            w_idx = IW'(w_tmp);
            if (i_valid[w_idx]) begin
                o_winner        = '0;
                o_winner[w_idx] = 1'b1;
            end
        end
    end

    assign o_any = |i_valid;

endmodule

// File: rtl/simd_mem_req_arbiter.sv
// simd_mem_req_arbiter: round-robin share of the SIMD 4 KB splitter
// Optional perf counters under `SIMD_ARB_PERF_CNT_EN
module simd_mem_req_arbiter
    import simd_arb_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int ADDR_WIDTH      = 64,
    parameter int REQ_SIZE_WIDTH  = 16,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic clk,
    input  logic reset,
    simd_mem_req_arbiter_if.slave bus
`ifdef SIMD_ARB_PERF_CNT_EN
    ,
    output logic [NUM_REQ-1:0][SIMD_ARB_CNT_W-1:0] perf_grant_cnt,
    output logic [SIMD_ARB_CNT_W-1:0]              perf_stall_cnt
`endif
);
    localparam int GW = $clog2(NUM_REQ);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    // Two beats of headroom: one split can emit two AWs
    localparam logic [OW-1:0] CREDIT_LIM = OW'(MAX_OUTSTANDING - 2);

    simd_arb_state_e         r_state;
    simd_arb_state_e         w_state_nxt;
    logic [GW-1:0]           r_last_grant;
    logic [GW-1:0]           r_grant_id;
    logic [GW-1:0]           w_win_idx;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [REQ_SIZE_WIDTH-1:0] r_size;
    logic [OW-1:0]           r_outstanding;
    logic                    r_credit_err;
    logic [NUM_REQ-1:0]      w_winner;
    logic                    w_any;
    logic                    w_credit_ok;
    logic                    w_accept;

    rr_pick #(
        .N (NUM_REQ)
    ) u_pick (
        .i_valid      (bus.req_valid),
        .i_last_grant (r_last_grant),
        .o_winner     (w_winner),
        .o_any        (w_any)
    );

    assign w_credit_ok = (r_outstanding <= CREDIT_LIM);
    assign w_accept    = (r_state == IDLE) && w_any && w_credit_ok;

    // One-hot winner to requester index
    always_comb begin
        w_win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_winner[i]) w_win_idx = GW'(i);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:      if (w_accept) w_state_nxt = ISSUE;
            ISSUE:     w_state_nxt = ARM;
            // Splitter complete is still high from its idle state here
            ARM:       w_state_nxt = WAIT_DONE;
            WAIT_DONE: if (bus.spl_complete) w_state_nxt = IDLE;
            default:   w_state_nxt = IDLE;
        endcase
    end

    // Output decode from registered state and latched request
    always_comb begin
        bus.req_ready      = w_accept ? w_winner : '0;
        bus.spl_addr_valid = (r_state == ISSUE);
        bus.busy           = (r_state != IDLE);
        bus.spl_addr       = r_addr;
        bus.spl_size       = r_size;
        bus.grant_id       = r_grant_id;
        bus.credit_err     = r_credit_err;
    end

    // Latch the winner's request on acceptance
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr       <= '0;
            r_size       <= '0;
            r_grant_id   <= '0;
            r_last_grant <= GW'(NUM_REQ - 1);
        end else if (w_accept) begin
            r_addr       <= bus.req_addr[w_win_idx];
            r_size       <= bus.req_size[w_win_idx];
            r_grant_id   <= w_win_idx;
            r_last_grant <= w_win_idx;
        end
    end

    // Outstanding AW tracking; underflow sets the sticky error
    always_ff @(posedge clk) begin
        if (reset) begin
            r_outstanding <= '0;
            r_credit_err  <= 1'b0;
        end else begin
            case ({bus.spl_issue, bus.wr_resp_valid})
                2'b10: r_outstanding <= r_outstanding + 1'b1;
                2'b01: begin
                    if (r_outstanding == '0) r_credit_err  <= 1'b1;
                    else                     r_outstanding <= r_outstanding - 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef SIMD_ARB_PERF_CNT_EN
    logic [NUM_REQ-1:0][SIMD_ARB_CNT_W-1:0] r_grant_cnt;
    logic [SIMD_ARB_CNT_W-1:0]              r_stall_cnt;

    // Saturating per-requester grants and credit-stall cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_accept && w_winner[i] && (r_grant_cnt[i] != '1))
                    r_grant_cnt[i] <= r_grant_cnt[i] + 1'b1;
            end
            if ((r_state == IDLE) && w_any && !w_credit_ok)
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign perf_grant_cnt = r_grant_cnt;
    assign perf_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_simd_mem_req_arbiter.sv
// Testbench for simd_mem_req_arbiter
// Per-cycle vector table plus a hand-written mid-transaction reset
module tb_simd_mem_req_arbiter;

    typedef struct {
        logic [3:0] valid;
        logic       iss;
        logic       rsp;
        logic       cmp;
        logic [3:0] ready;
        logic       sav;
        logic [1:0] gid;
        logic       busy;
        logic       cerr;
        int         outs;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [63:0] tb_addr [4];
    logic [15:0] tb_size [4];
    vec_t        tbl [$];

    simd_mem_req_arbiter_if #(
        .NUM_REQ(4), .ADDR_WIDTH(64), .REQ_SIZE_WIDTH(16)
    ) bus ();

`ifdef SIMD_ARB_PERF_CNT_EN
    logic [3:0][31:0] perf_grant_cnt;
    logic [31:0]      perf_stall_cnt;
`endif

    simd_mem_req_arbiter #(
        .NUM_REQ(4), .ADDR_WIDTH(64),
        .REQ_SIZE_WIDTH(16), .MAX_OUTSTANDING(4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
`ifdef SIMD_ARB_PERF_CNT_EN
        ,
        .perf_grant_cnt (perf_grant_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(
        logic [3:0] v, logic iss, logic rsp, logic cmp,
        logic [3:0] rdy, logic sav, logic [1:0] gid,
        logic busy, logic cerr, int outs
    );
        vec_t r;
        r.valid = v;   r.iss = iss;  r.rsp = rsp;   r.cmp = cmp;
        r.ready = rdy; r.sav = sav;  r.gid = gid;
        r.busy = busy; r.cerr = cerr; r.outs = outs;
        return r;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(logic [3:0] v, logic iss, logic rsp, logic cmp);
        bus.req_valid     = v;
        bus.spl_issue     = iss;
        bus.wr_resp_valid = rsp;
        bus.spl_complete  = cmp;
        for (int i = 0; i < 4; i++) begin
            bus.req_addr[i] = tb_addr[i];
            bus.req_size[i] = tb_size[i];
        end
    endtask

    initial begin
        logic [3:0] v;
        int         gp;

        tb_addr[0] = 64'h1000; tb_size[0] = 16'd256;
        tb_addr[1] = 64'h0FC0; tb_size[1] = 16'd128;
        tb_addr[2] = 64'h2000; tb_size[2] = 16'd64;
        tb_addr[3] = 64'h3000; tb_size[3] = 16'd512;

        // All four valid: grant order 0,1,2,3,0
        for (int k = 0; k < 5; k++) begin
            gp = (k == 0) ? 0 : k - 1;
            v  = (k < 4) ? 4'hF : 4'h0;
            tbl.push_back(mk(4'hF, 0, 0, 1, 4'(1 << k % 4), 0, 2'(gp), 0, 0, 0));
            tbl.push_back(mk(v, 0, 0, 1, 4'h0, 1, 2'(k % 4), 1, 0, 0));
            tbl.push_back(mk(v, 0, 0, 1, 4'h0, 0, 2'(k % 4), 1, 0, 0));
            tbl.push_back(mk(v, 0, 0, 1, 4'h0, 0, 2'(k % 4), 1, 0, 0));
        end
        // Single requester 0, one AW, completes 4 cycles after pulse
        tbl.push_back(mk(4'h1, 0, 0, 1, 4'h1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(4'h0, 0, 0, 1, 4'h0, 1, 0, 1, 0, 0));
        tbl.push_back(mk(4'h0, 1, 0, 0, 4'h0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(4'h0, 0, 0, 0, 4'h0, 0, 0, 1, 0, 1));
        tbl.push_back(mk(4'h0, 0, 0, 0, 4'h0, 0, 0, 1, 0, 1));
        tbl.push_back(mk(4'h0, 0, 0, 1, 4'h0, 0, 0, 1, 0, 1));
        // Split 0x0FC0/128: two AWs, requester 2 waits, then credit block
        tbl.push_back(mk(4'h6, 0, 0, 1, 4'h2, 0, 0, 0, 0, 1));
        tbl.push_back(mk(4'h4, 0, 0, 1, 4'h0, 1, 1, 1, 0, 1));
        tbl.push_back(mk(4'h4, 1, 0, 0, 4'h0, 0, 1, 1, 0, 1));
        tbl.push_back(mk(4'h4, 1, 0, 0, 4'h0, 0, 1, 1, 0, 2));
        tbl.push_back(mk(4'h4, 0, 0, 0, 4'h0, 0, 1, 1, 0, 3));
        tbl.push_back(mk(4'h4, 0, 0, 1, 4'h0, 0, 1, 1, 0, 3));
        tbl.push_back(mk(4'h4, 0, 0, 1, 4'h0, 0, 1, 0, 0, 3));
        tbl.push_back(mk(4'h4, 0, 1, 1, 4'h0, 0, 1, 0, 0, 3));
        tbl.push_back(mk(4'h4, 0, 0, 1, 4'h4, 0, 1, 0, 0, 2));
        // Issue and response together, then underflow
        tbl.push_back(mk(4'h0, 0, 0, 1, 4'h0, 1, 2, 1, 0, 2));
        tbl.push_back(mk(4'h0, 1, 1, 0, 4'h0, 0, 2, 1, 0, 2));
        tbl.push_back(mk(4'h0, 0, 0, 0, 4'h0, 0, 2, 1, 0, 2));
        tbl.push_back(mk(4'h0, 0, 1, 1, 4'h0, 0, 2, 1, 0, 2));
        tbl.push_back(mk(4'h0, 0, 1, 1, 4'h0, 0, 2, 0, 0, 1));
        tbl.push_back(mk(4'h0, 0, 1, 1, 4'h0, 0, 2, 0, 0, 0));
        tbl.push_back(mk(4'h0, 0, 0, 1, 4'h0, 0, 2, 0, 1, 0));
        tbl.push_back(mk(4'h0, 0, 0, 1, 4'h0, 0, 2, 0, 1, 0));

        reset = 1'b1;
        drive(4'h0, 0, 0, 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.ready", 64'(bus.req_ready), 64'h0);
        chk("rst.sav", 64'(bus.spl_addr_valid), 64'h0);
        chk("rst.addr", bus.spl_addr, 64'h0);
        chk("rst.size", 64'(bus.spl_size), 64'h0);
        chk("rst.gid", 64'(bus.grant_id), 64'h0);
        chk("rst.busy", 64'(bus.busy), 64'h0);
        chk("rst.cerr", 64'(bus.credit_err), 64'h0);
        chk("rst.outs", 64'(dut.r_outstanding), 64'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].valid, tbl[i].iss, tbl[i].rsp, tbl[i].cmp);
            @(negedge clk);
            chk($sformatf("v%0d.ready", i), 64'(bus.req_ready), 64'(tbl[i].ready));
            chk($sformatf("v%0d.sav", i), 64'(bus.spl_addr_valid), 64'(tbl[i].sav));
            chk($sformatf("v%0d.gid", i), 64'(bus.grant_id), 64'(tbl[i].gid));
            chk($sformatf("v%0d.busy", i), 64'(bus.busy), 64'(tbl[i].busy));
            chk($sformatf("v%0d.cerr", i), 64'(bus.credit_err), 64'(tbl[i].cerr));
            chk($sformatf("v%0d.outs", i), 64'(dut.r_outstanding), 64'(tbl[i].outs));
            if (tbl[i].sav) begin
                chk($sformatf("v%0d.addr", i), bus.spl_addr, tb_addr[tbl[i].gid]);
                chk($sformatf("v%0d.size", i), 64'(bus.spl_size),
                    64'(tb_size[tbl[i].gid]));
            end
            @(posedge clk);
            #1;
        end

        // Reset in WAIT_DONE with one AW outstanding and sticky error set
        drive(4'h8, 0, 0, 1);
        @(negedge clk);
        chk("h.grant3", 64'(bus.req_ready), 64'h8);
        @(posedge clk); #1;
        drive(4'h0, 0, 0, 1);
        @(negedge clk);
        chk("h.sav", 64'(bus.spl_addr_valid), 64'h1);
        chk("h.gid", 64'(bus.grant_id), 64'h3);
        chk("h.addr", bus.spl_addr, tb_addr[3]);
        @(posedge clk); #1;
        drive(4'h0, 1, 0, 0);
        @(posedge clk); #1;
        drive(4'h0, 0, 0, 0);
        @(negedge clk);
        chk("h.busy_wait", 64'(bus.busy), 64'h1);
        chk("h.outs_wait", 64'(dut.r_outstanding), 64'h1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("h.busy_rst_req", 64'(bus.busy), 64'h1);
        @(posedge clk); #1;
        reset = 1'b0;
        drive(4'hF, 0, 0, 1);
        @(negedge clk);
        chk("h.busy_after", 64'(bus.busy), 64'h0);
        chk("h.outs_after", 64'(dut.r_outstanding), 64'h0);
        chk("h.cerr_after", 64'(bus.credit_err), 64'h0);
        chk("h.gid_after", 64'(bus.grant_id), 64'h0);
        chk("h.ready_after", 64'(bus.req_ready), 64'h1);
        @(posedge clk); #1;
        drive(4'h0, 0, 0, 1);
        @(negedge clk);
        chk("h.sav_after", 64'(bus.spl_addr_valid), 64'h1);
        chk("h.addr_after", bus.spl_addr, tb_addr[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
